mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Round-robin arbiter that shares the single-port memory bus (addr/wr_en/valid/wdata/rdata) between NUM_REQ requesters, e.g. the register-access agent and a background DMA/scrub engine.
- Accepts one request at a time on a valid/ready handshake.
- Issues it to memory as a one-cycle valid pulse.
- Waits for read data, then returns a one-cycle response to the granted requester.
- Sits directly in front of the memory, on the same clock.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LATENCY, 1, cycles from mem_valid (read) to mem_rdata valid (1..15)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid&ready
req_wr_en  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
mem_addr  out  ADDR_W  memory address
mem_wr_en  out  1  memory write enable
mem_valid  out  1  memory access strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and the RR pointer is NUM_REQ-1, so requester 0 wins first.
- Reset takes effect at the next posedge in any state. An in-flight access is dropped with no rsp_valid, and mem_valid is 0 from the following cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_valid:
  - Select g = first asserted index searching from pointer+1 with wrap.
  - Assert req_ready[g] combinationally in this cycle.
  - Latch addr/wr_en/wdata of g, set pointer=g, go to ISSUE.
  - With no req_valid, stay in IDLE and keep req_ready=0.
- ISSUE, exactly one cycle:
  - mem_valid=1, mem_addr/mem_wr_en/mem_wdata = latched values.
  - Write: next state RESP. Read: load counter=RD_LATENCY, next state WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into rsp_rdata and go to RESP.
  - Occupies RD_LATENCY cycles.
- RESP, one cycle:
  - rsp_valid[g]=1. rsp_rdata = captured data for reads, 0 for writes.
  - Next state IDLE.
- Latency, with acceptance in cycle T: mem_valid at T+1; write rsp at T+2; read rsp at T+2+RD_LATENCY. Next acceptance is no earlier than the cycle after RESP.
- req_ready is 0 outside IDLE. Requesters hold their fields stable while valid&!ready, and may drop valid without being accepted.
- rsp_valid has no back-pressure; requesters must accept it.
- mem_* outputs hold their last values when mem_valid=0. mem_wr_en/mem_wdata are 0 after reset until the first issue.
- Fairness: a requester continuously asserting valid is granted within NUM_REQ arbitrations.
- Simultaneous requests are resolved only by the pointer.

Decomposition:
- Package mem_arb_pkg:
  - state_e enum (IDLE, ISSUE, WAIT, RESP)
  - localparam CNT_W=4
  - function rr_pick(req, ptr) returning a one-hot grant
- Sub-module rr_arbiter: holds the pointer register, with combinational grant from req_valid & IDLE and a pointer update on accept.
- mem_bus_arbiter owns the FSM, the latches and the latency counter.

Test Plan:
1. req0 write addr 0x10, wdata 0xDEADBEEF at T -> req_ready[0] at T; mem_valid=1, mem_wr_en=1, mem_addr=0x10 at T+1; rsp_valid=2'b01, rsp_rdata=0 at T+2.
2. Then req1 read addr 0x10, memory model RD_LATENCY=1 -> mem_valid, mem_wr_en=0 at T+1; rsp_valid=2'b10, rsp_rdata=0xDEADBEEF at T+3.
3. Both requesters hold valid for 8 transactions after reset -> grant order 0,1,0,1,...; no requester granted twice in a row.
4. RD_LATENCY=3 build, read from req0 -> rsp_valid at T+5 with model data; busy high T+1..T+5.
5. rst pulsed during WAIT -> mem_valid=0 and no rsp_valid afterwards; all outputs 0; with both valid, the next grant goes to req0.
6. Only req1 writes, back-to-back -> accepted every 3 cycles; req0 asserts mid-stream -> req0 is granted at the next IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types, constants and round-robin pick for mem_bus_arbiter
// Rev     : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int CNT_W   = 4;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // Requests above NUM_REQ are zero, so wrapping modulo 8 searches the
    // same order as wrapping modulo NUM_REQ.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr);
        logic [MAX_REQ-1:0] gnt;
        logic [IDX_W-1:0]   idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_if
// Brief   : Requester handshake, response and memory bus signals
// Rev     : 1.0
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_wr_en;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_wr_en;
    logic                      mem_valid;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    // Arbiter side: accepts requests and masters the memory bus.
    modport master (
        input  req_valid, req_wr_en, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_addr, mem_wr_en, mem_valid, mem_wdata
    );

    modport slave (
        output req_valid, req_wr_en, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_addr, mem_wr_en, mem_valid, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin grant with pointer register, updated on accept
// Rev     : 1.0
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic               i_idle,
    output logic      [NUM_REQ-1:0] o_grant
);
    logic [MAX_REQ-1:0] w_req;
    logic [MAX_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   r_ptr;

    always_comb begin
        w_req                = '0;
        w_req[NUM_REQ-1:0]   = i_idle ? i_req : '0;
    end

    assign w_pick  = rr_pick(w_req, r_ptr);
    assign o_grant = w_pick[NUM_REQ-1:0];

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (w_pick[i]) w_idx = IDX_W'(i);
        end
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst)          r_ptr <= IDX_W'(NUM_REQ - 1);
        else if (|w_pick) r_ptr <= w_idx;
    end
endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Round-robin sharing of a single-port memory bus between requesters
// Rev     : 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_bus_arbiter_if.master  bus,
    output logic               busy
);
    state_e               r_state, w_next;
    logic                 w_idle, w_accept;
    logic [NUM_REQ-1:0]   w_grant;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;
    logic                 r_mem_valid, w_mem_valid_d;
    logic                 r_mem_wr, w_mem_wr_d;
    logic [ADDR_W-1:0]    r_mem_addr, w_mem_addr_d;
    logic [DATA_W-1:0]    r_mem_wdata, w_mem_wdata_d;
    logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_d;
    logic [DATA_W-1:0]    r_rsp_rdata, w_rsp_rdata_d;

    // Ready is withheld while rst is high, since the accept would be dropped.
    assign w_idle   = (r_state == IDLE) && !rst;
    assign w_accept = |w_grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req   (bus.req_valid),
        .i_idle  (w_idle),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE:   w_next = r_mem_wr ? RESP : WAIT;
            WAIT:    if (r_cnt == CNT_W'(1)) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; the mem_* registers double as
    // the request latch and hold between accesses.
    always_comb begin
        w_mem_valid_d = 1'b0;
        w_mem_wr_d    = r_mem_wr;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_rsp_valid_d = '0;
        w_rsp_rdata_d = '0;
        w_cnt_d       = r_cnt;
        w_gnt_d       = r_gnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mem_valid_d = 1'b1;
                    w_gnt_d       = w_grant;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_grant[i]) begin
                            w_mem_wr_d    = bus.req_wr_en[i];
                            w_mem_addr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
                            w_mem_wdata_d = bus.req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ISSUE: begin
                w_cnt_d = CNT_W'(RD_LATENCY);
                if (r_mem_wr) w_rsp_valid_d = r_gnt;
            end
            WAIT: begin
                w_cnt_d = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_rsp_valid_d = r_gnt;
                    w_rsp_rdata_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            busy        <= 1'b0;
        end else begin
            r_mem_valid <= w_mem_valid_d;
            r_mem_wr    <= w_mem_wr_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_cnt       <= w_cnt_d;
            r_gnt       <= w_gnt_d;
            busy        <= (w_next != IDLE);
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_wr_en = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
`default_nettype wire
